// File: rtl/mem_req_sel_n.sv
// MEM-stage memory request select: picks the lowest-index load/store lane,
// checks the held TLB result and raises address/TLB exceptions, drives the
// dcache req/addr_ok/data_ok handshake, and keeps a tag FIFO of up to
// OUTSTANDING accepted requests so that load data returns aligned, extended
// and tagged with its lane.
// Ports: clk, reset (sync, active-high), stall; lane_* bundle inputs;
//   tlb_* lookup result; data_* dcache request/response; rsp_* load result;
//   exc_*/bad_vaddr exception report; stall_req back to the pipeline.
// Build option: MEM_REQ_UNALIGN_EN adds SWL/SWR strobe and data shaping
//   for word stores; without it lane_unl/lane_unr do not affect requests.
module mem_req_sel_n #(
  parameter int LANES       = 2,
  parameter int OUTSTANDING = 2,
  parameter int LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [LANES-1:0]  lane_accmem,
  input  logic [LANES-1:0]  lane_wr,
  input  logic [LANES-1:0]  lane_sext,
  input  logic [LANES-1:0]  lane_unl,
  input  logic [LANES-1:0]  lane_unr,
  input  logic [2*LANES-1:0]  lane_size,
  input  logic [32*LANES-1:0] lane_wdata,
  input  logic [31:0]       tlb_paddr,
  input  logic [31:0]       tlb_vaddr,
  input  logic              tlb_cached,
  input  logic              tlb_hit,
  input  logic              tlb_v,
  input  logic              tlb_d,
  input  logic              tlb_error,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic              data_cached,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              rsp_valid,
  output logic [LW-1:0]     rsp_lane,
  output logic [31:0]       rsp_data,
  output logic              exc_valid,
  output logic [LW-1:0]     exc_lane,
  output logic [4:0]        exc_code,
  output logic              exc_tre,
  output logic [31:0]       bad_vaddr,
  output logic              stall_req
);

  localparam int AW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] FULL = CW'(OUTSTANDING);

  typedef struct packed {
    logic [31:0] paddr;
    logic [31:0] vaddr;
    logic        cached;
    logic        hit;
    logic        v;
    logic        d;
    logic        err;
  } tlb_t;

  typedef struct packed {
    logic [LW-1:0] lane;
    logic [1:0]    size;
    logic          sext;
    logic [1:0]    a;
    logic          unl;
    logic          unr;
    logic          is_load;
  } tag_t;

  tlb_t live, held, t;
  logic hold_v, done;

  assign live = {tlb_paddr, tlb_vaddr, tlb_cached,
                 tlb_hit, tlb_v, tlb_d, tlb_error};
  // A held bundle keeps seeing the TLB result of its first stall cycle.
  assign t = hold_v ? held : live;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v <= 1'b0;
      held   <= '0;
    end else if (!stall) begin
      hold_v <= 1'b0;
    end else if (!hold_v) begin
      hold_v <= 1'b1;
      held   <= live;
    end
  end

  logic          sel_v;
  logic [LW-1:0] sel;

  always_comb begin
    sel_v = 1'b0;
    sel   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_accmem[i]) begin
        sel_v = 1'b1;
        sel   = LW'(i);
      end
    end
  end

  logic        s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_src;

  assign s_wr   = lane_wr[sel];
  assign s_size = lane_size[{sel, 1'b0} +: 2];
  assign s_src  = lane_wdata[{sel, 5'd0} +: 32];

  logic [4:0] code;
  logic       tre;

  always_comb begin
    code = 5'd0;
    tre  = 1'b0;
    if (t.err) begin
      code = s_wr ? 5'd5 : 5'd4;
    end else if (!t.hit || !t.v) begin
      code = s_wr ? 5'd3 : 5'd2;
      tre  = !t.hit;
    end else if (s_wr && !t.d) begin
      code = 5'd1;
    end
  end

  logic          exc, req, push, pop, full, pend;
  logic [CW-1:0] cnt;

  assign exc  = sel_v & (code != 5'd0);
  assign full = (cnt == FULL);
  assign pend = sel_v & ~exc & ~done;
  assign req  = pend & ~full & ~reset;
  assign push = req & data_addr_ok;
  assign pop  = data_data_ok & (cnt != '0) & ~reset;

  // done blocks a second request for a bundle the pipeline is holding.
  always_ff @(posedge clk) begin
    if (reset)       done <= 1'b0;
    else if (!stall) done <= 1'b0;
    else if (push)   done <= 1'b1;
  end

  logic [1:0]  a;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  assign a = t.paddr[1:0];

  always_comb begin
    wstrb = 4'b1111;
    wdata = s_src;
    case (s_size)
      2'd0: begin
        wstrb = 4'b0001 << a;
        wdata = {24'd0, s_src[7:0]} << {a, 3'b000};
      end
      2'd1: begin
        wstrb = 4'b0011 << {a[1], 1'b0};
        wdata = {16'd0, s_src[15:0]} << {a[1], 4'b0000};
      end
      default: begin
`ifdef MEM_REQ_UNALIGN_EN
        if (lane_unl[sel]) begin
          wstrb = 4'b1111 >> ~a;
          wdata = s_src >> {~a, 3'b000};
        end else if (lane_unr[sel]) begin
          wstrb = 4'b1111 << a;
          wdata = s_src << {a, 3'b000};
        end
`endif
      end
    endcase
  end

  tag_t          fifo [DEPTH];
  tag_t          new_tag, head;
  logic [AW-1:0] wp, rp;

  assign new_tag = '{
    lane:    sel,
    size:    s_size,
    sext:    lane_sext[sel],
    a:       a,
    unl:     lane_unl[sel],
    unr:     lane_unr[sel],
    is_load: ~s_wr
  };
  assign head = fifo[rp];

  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= new_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  logic unused_tag;
  assign unused_tag = ^{head.unl, head.unr};

  logic [31:0] sh, ext;

  assign sh = data_rdata >> {head.a, 3'b000};

  always_comb begin
    case (head.size)
      2'd0:    ext = {{24{head.sext & sh[7]}}, sh[7:0]};
      2'd1:    ext = {{16{head.sext & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  assign data_req = req;

  always_comb begin
    data_wr     = 1'b0;
    data_size   = '0;
    data_addr   = '0;
    data_cached = 1'b0;
    data_wstrb  = '0;
    data_wdata  = '0;
    exc_valid   = 1'b0;
    exc_lane    = '0;
    exc_code    = '0;
    exc_tre     = 1'b0;
    bad_vaddr   = '0;
    rsp_valid   = 1'b0;
    rsp_lane    = '0;
    rsp_data    = '0;
    stall_req   = 1'b0;
    if (!reset) begin
      data_wr     = sel_v & s_wr;
      data_size   = s_size;
      data_addr   = t.paddr;
      data_cached = t.cached;
      data_wstrb  = s_wr ? wstrb : 4'b0000;
      data_wdata  = wdata;
      exc_valid   = exc;
      exc_lane    = sel;
      exc_code    = exc ? code : 5'd0;
      exc_tre     = exc & tre;
      bad_vaddr   = t.vaddr;
      rsp_valid   = pop & head.is_load;
      rsp_lane    = rsp_valid ? head.lane : '0;
      rsp_data    = rsp_valid ? ext : 32'd0;
      stall_req   = (req & ~data_addr_ok) | (full & pend);
    end
  end

endmodule

// File: tb/tb_mem_req_sel_n.sv
// Bench for mem_req_sel_n: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_mem_req_sel_n;
  localparam int LANES = 2;
  localparam int OUT   = 2;
  localparam int LW    = 1;

  logic clk, reset, stall;
  logic [LANES-1:0] lane_accmem, lane_wr, lane_sext, lane_unl, lane_unr;
  logic [2*LANES-1:0]  lane_size;
  logic [32*LANES-1:0] lane_wdata;
  logic [31:0] tlb_paddr, tlb_vaddr;
  logic tlb_cached, tlb_hit, tlb_v, tlb_d, tlb_error;
  logic data_req, data_wr, data_cached;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0] data_wstrb;
  logic data_addr_ok, data_data_ok;
  logic rsp_valid, exc_valid, exc_tre, stall_req;
  logic [LW-1:0] rsp_lane, exc_lane;
  logic [31:0] rsp_data, bad_vaddr;
  logic [4:0] exc_code;

  mem_req_sel_n #(.LANES(LANES), .OUTSTANDING(OUT)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .lane_accmem(lane_accmem), .lane_wr(lane_wr),
    .lane_sext(lane_sext), .lane_unl(lane_unl),
    .lane_unr(lane_unr), .lane_size(lane_size),
    .lane_wdata(lane_wdata),
    .tlb_paddr(tlb_paddr), .tlb_vaddr(tlb_vaddr),
    .tlb_cached(tlb_cached), .tlb_hit(tlb_hit),
    .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_error(tlb_error),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_cached(data_cached), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .rsp_valid(rsp_valid), .rsp_lane(rsp_lane),
    .rsp_data(rsp_data), .exc_valid(exc_valid),
    .exc_lane(exc_lane), .exc_code(exc_code),
    .exc_tre(exc_tre), .bad_vaddr(bad_vaddr),
    .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int lane;
    int size;
    bit sext;
    int a;
    bit load;
  } tag_m;

  tag_m q[$];
  bit m_hold = 0;
  bit m_done = 0;
  logic [31:0] hp, hv;
  bit hc, hh, hvb, hd, he;

  initial begin
    bit found, st, e_exc, e_req, e_pop, e_rv, e_stall;
    int sl, sz, code, a, h;
    logic [31:0] pa, va, src, es, ew, v;
    bit ca, hi, vb, dd, er;
    forever begin
      @(negedge clk);
      #2;
      e_req = 0;
      e_pop = 0;
      if (reset) begin
        chk("rst_req", data_req, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_exc", exc_valid, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_rdata", rsp_data, 0);
        chk("rst_bva", bad_vaddr, 0);
      end else begin
        found = 0;
        sl = 0;
        for (int i = 0; i < LANES; i++)
          if (lane_accmem[i] && !found) begin
            found = 1;
            sl = i;
          end
        st  = lane_wr[sl];
        sz  = int'(lane_size[2*sl +: 2]);
        src = lane_wdata[32*sl +: 32];
        pa = m_hold ? hp  : tlb_paddr;
        va = m_hold ? hv  : tlb_vaddr;
        ca = m_hold ? hc  : tlb_cached;
        hi = m_hold ? hh  : tlb_hit;
        vb = m_hold ? hvb : tlb_v;
        dd = m_hold ? hd  : tlb_d;
        er = m_hold ? he  : tlb_error;
        if (er)              code = st ? 5 : 4;
        else if (!hi || !vb) code = st ? 3 : 2;
        else if (st && !dd)  code = 1;
        else                 code = 0;
        e_exc = found && code != 0;
        e_req = found && !e_exc && !m_done && q.size() < OUT;
        chk("req", data_req, e_req);
        chk("exc_v", exc_valid, e_exc);
        if (e_exc) begin
          chk("exc_code", exc_code, code);
          chk("exc_lane", exc_lane, sl);
          chk("exc_tre", exc_tre, (code == 2 || code == 3) && !hi);
          chk("bad_vaddr", bad_vaddr, va);
        end
        a = int'(pa % 4);
        if (e_req) begin
          chk("wr", data_wr, st);
          chk("size", data_size, sz);
          chk("addr", data_addr, pa);
          chk("cached", data_cached, ca);
          if (st) begin
            if (sz == 0) begin
              es = 1 << a;
              ew = (src % 256) * (32'd1 << (8 * a));
            end else if (sz == 1) begin
              h  = a / 2;
              es = 3 << (2 * h);
              ew = (src % 65536) * (h ? 32'd65536 : 32'd1);
            end else begin
              es = 15;
              ew = src;
            end
            chk("wstrb", data_wstrb, es);
            chk("wdata", data_wdata, ew);
          end
        end
        e_stall = (e_req && !data_addr_ok) ||
                  (q.size() == OUT && found && !e_exc && !m_done);
        chk("stall_req", stall_req, e_stall);
        e_pop = data_data_ok && q.size() > 0;
        e_rv  = e_pop && q[0].load;
        chk("rsp_v", rsp_valid, e_rv);
        if (e_rv) begin
          v = data_rdata >> (8 * q[0].a);
          if (q[0].size == 0) begin
            v = v % 256;
            if (q[0].sext && v >= 128) v = v + 32'hFFFF_FF00;
          end else if (q[0].size == 1) begin
            v = v % 65536;
            if (q[0].sext && v >= 32768) v = v + 32'hFFFF_0000;
          end
          chk("rsp_lane", rsp_lane, q[0].lane);
          chk("rsp_data", rsp_data, v);
        end
      end
      @(posedge clk);
      if (reset) begin
        q.delete();
        m_hold = 0;
        m_done = 0;
      end else begin
        if (e_pop) void'(q.pop_front());
        if (e_req && data_addr_ok)
          q.push_back('{sl, sz, lane_sext[sl], a, !st});
        if (!stall) begin
          m_hold = 0;
          m_done = 0;
        end else begin
          if (e_req && data_addr_ok) m_done = 1;
          if (!m_hold) begin
            m_hold = 1;
            hp = tlb_paddr; hv = tlb_vaddr; hc = tlb_cached;
            hh = tlb_hit; hvb = tlb_v; hd = tlb_d; he = tlb_error;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tlb_ok(logic [31:0] pa);
    tlb_paddr  = pa;
    tlb_vaddr  = pa ^ 32'h8000_0000;
    tlb_cached = 1'b1;
    tlb_hit    = 1'b1;
    tlb_v      = 1'b1;
    tlb_d      = 1'b1;
    tlb_error  = 1'b0;
  endtask

  task automatic hs(logic aok, logic dok);
    data_addr_ok = aok;
    data_data_ok = dok;
  endtask

  task automatic load_w(logic [LANES-1:0] acc);
    lane_accmem = acc;
    lane_wr     = '0;
    lane_sext   = '0;
    lane_size   = 4'b1010;
  endtask

  bit stall_prev;

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    lane_accmem = '0; lane_wr = '0; lane_sext = '0;
    lane_unl = '0; lane_unr = '0; lane_size = '0;
    lane_wdata = '0; data_rdata = '0;
    tlb_ok(32'h0);
    hs(0, 0);

    // reset holds every output low even with a live request
    repeat (2) begin
      @(negedge clk);
      reset = 1'b1;
      load_w(2'b01);
      hs(1, 1);
      #3 chk("d_rst_req", data_req, 0);
      chk("d_rst_rsp", rsp_valid, 0);
    end

    // lane 1 word load accepted immediately
    @(negedge clk);
    reset = 1'b0;
    load_w(2'b10);
    tlb_ok(32'h1000_0004);
    hs(1, 0);
    #3 chk("d_ld_req", data_req, 1);
    chk("d_ld_addr", data_addr, 32'h1000_0004);
    chk("d_ld_stall", stall_req, 0);

    @(negedge clk);
    lane_accmem = '0;
    hs(0, 1);
    data_rdata = 32'hDEAD_BEEF;
    #3 chk("d_ld_rv", rsp_valid, 1);
    chk("d_ld_lane", rsp_lane, 1);
    chk("d_ld_data", rsp_data, 32'hDEAD_BEEF);

    // store byte at a=3, not yet accepted
    @(negedge clk);
    lane_accmem = 2'b01;
    lane_wr     = 2'b01;
    lane_size   = 4'b0000;
    lane_wdata  = 64'h0000_0000_0000_00A5;
    tlb_ok(32'h2000_0003);
    hs(0, 0);
    #3 chk("d_sb_req", data_req, 1);
    chk("d_sb_strb", data_wstrb, 4'b1000);
    chk("d_sb_wdata", data_wdata, 32'hA500_0000);
    chk("d_sb_stall", stall_req, 1);

    // store to clean page
    @(negedge clk);
    tlb_d = 1'b0;
    #3 chk("d_mod_v", exc_valid, 1);
    chk("d_mod_code", exc_code, 1);
    chk("d_mod_req", data_req, 0);

    // load TLB miss
    @(negedge clk);
    lane_wr   = '0;
    tlb_d     = 1'b1;
    tlb_hit   = 1'b0;
    tlb_vaddr = 32'h1234_5678;
    #3 chk("d_miss_code", exc_code, 2);
    chk("d_miss_tre", exc_tre, 1);
    chk("d_miss_bva", bad_vaddr, 32'h1234_5678);

    // held bundle: one handshake, cycle-0 TLB result kept
    @(negedge clk);
    load_w(2'b01);
    tlb_ok(32'h3000_0008);
    stall = 1'b1;
    hs(0, 0);
    #3 chk("d_h0_req", data_req, 1);
    chk("d_h0_stall", stall_req, 1);
    @(negedge clk);
    hs(1, 0);
    #3 chk("d_h1_req", data_req, 1);
    chk("d_h1_stall", stall_req, 0);
    @(negedge clk);
    tlb_hit   = 1'b0;
    tlb_error = 1'b1;
    #3 chk("d_h2_exc", exc_valid, 0);
    chk("d_h2_req", data_req, 0);
    @(negedge clk);
    stall = 1'b0;
    hs(0, 0);
    #3 chk("d_h3_exc", exc_valid, 0);
    chk("d_h3_req", data_req, 0);

    @(negedge clk);
    lane_accmem = '0;
    tlb_ok(32'h0);
    hs(0, 1);
    data_rdata = 32'h1122_3344;
    #3 chk("d_h_rsp", rsp_data, 32'h1122_3344);

    // fill to OUTSTANDING
    @(negedge clk);
    load_w(2'b01);
    tlb_ok(32'h4000_0000);
    hs(1, 0);
    #3 chk("d_o1_req", data_req, 1);
    @(negedge clk);
    #3 chk("d_o2_req", data_req, 1);
    @(negedge clk);
    #3 chk("d_o3_req", data_req, 0);
    chk("d_o3_stall", stall_req, 1);
    @(negedge clk);
    hs(0, 1);
    data_rdata = 32'h0A0B_0C0D;
    #3 chk("d_o4_req", data_req, 0);
    chk("d_o4_rv", rsp_valid, 1);
    @(negedge clk);
    hs(1, 1);
    #3 chk("d_o5_req", data_req, 1);
    @(negedge clk);
    hs(1, 0);
    #3 chk("d_o6_req", data_req, 1);
    @(negedge clk);
    #3 chk("d_o7_req", data_req, 0);
    repeat (2) begin
      @(negedge clk);
      lane_accmem = '0;
      hs(0, 1);
    end

    // signed half at a=2
    @(negedge clk);
    lane_accmem = 2'b01;
    lane_wr     = '0;
    lane_sext   = 2'b01;
    lane_size   = 4'b0001;
    tlb_ok(32'h5000_0002);
    hs(1, 0);
    @(negedge clk);
    lane_accmem = '0;
    hs(0, 1);
    data_rdata = 32'h8001_0000;
    #3 chk("d_sh_data", rsp_data, 32'hFFFF_8001);

    // reset drops two in-flight tags
    repeat (2) begin
      @(negedge clk);
      load_w(2'b01);
      tlb_ok(32'h6000_0000);
      hs(1, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    hs(0, 0);
    @(negedge clk);
    reset = 1'b0;
    lane_accmem = '0;
    hs(0, 1);
    #3 chk("d_rf_rv", rsp_valid, 0);
    @(negedge clk);
    lane_accmem = 2'b01;
    hs(1, 0);
    #3 chk("d_rf_req", data_req, 1);
    @(negedge clk);
    lane_accmem = '0;
    hs(0, 1);

    // randomized traffic
    stall_prev = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      if (!stall_prev) begin
        lane_accmem = LANES'($urandom);
        lane_wr     = LANES'($urandom);
        lane_sext   = LANES'($urandom);
        lane_unl    = LANES'($urandom);
        lane_unr    = LANES'($urandom);
        for (int k = 0; k < LANES; k++) begin
          lane_size[2*k +: 2]   = 2'($urandom_range(0, 2));
          lane_wdata[32*k +: 32] = $urandom;
        end
      end
      stall = ($urandom_range(0, 2) == 0);
      stall_prev = stall;
      tlb_paddr  = $urandom;
      tlb_vaddr  = $urandom;
      tlb_cached = 1'($urandom);
      tlb_hit    = ($urandom_range(0, 9) != 0);
      tlb_v      = ($urandom_range(0, 9) != 0);
      tlb_d      = ($urandom_range(0, 7) != 0);
      tlb_error  = ($urandom_range(0, 19) == 0);
      data_addr_ok = 1'($urandom);
      data_data_ok = ($urandom_range(0, 4) < 2);
      data_rdata   = $urandom;
    end

    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
